// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package shifter_pkg;

  typedef enum logic [2:0] {
    MODE_SRL   = 3'b000,
    MODE_SRA   = 3'b001,
    MODE_SLL   = 3'b010,
    MODE_SLA   = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_ROL   = 3'b101,
    MODE_PASS  = 3'b110,
    MODE_PASS2 = 3'b111
  } shift_mode_t;

  // Ceiling log2; only ever evaluated on constants.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic is_left(input shift_mode_t m);
    return (m == MODE_SLL) || (m == MODE_SLA) || (m == MODE_ROL);
  endfunction

  function automatic logic is_rotate(input shift_mode_t m);
    return (m == MODE_ROR) || (m == MODE_ROL);
  endfunction

endpackage

// File: rtl/shifter_stage.sv
// One right-shift level by SHIFT bits, followed by its pipeline register.
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHIFT = 1,
  localparam int SW  = log2(WIDTH),
  localparam int BIT = log2(SHIFT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             flush,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  input  shift_mode_t      prev_mode,
  input  logic [SW-1:0]    prev_shamt,
  input  logic             prev_fill,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output shift_mode_t      mode,
  output logic [SW-1:0]    shamt,
  output logic             fill
);

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = prev_data;
    if (prev_shamt[BIT]) begin
      if (is_rotate(prev_mode))
        shifted = {prev_data[SHIFT-1:0], prev_data[WIDTH-1:SHIFT]};
      else
        shifted = {{SHIFT{prev_fill}}, prev_data[WIDTH-1:SHIFT]};
    end
  end

  // Only the valid bit is reset/flushed; payload just follows advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (advance) begin
      valid <= prev_valid;
      data  <= shifted;
      mode  <= prev_mode;
      shamt <= prev_shamt;
      fill  <= prev_fill;
    end
  end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter: left modes are bit-reversed around a shared
// right-shift datapath, one register per shift level, MSB level first.
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int STAGES = log2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [STAGES-1:0] in_shamt,
  input  shift_mode_t       in_mode,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data
);

  logic              advance;
  logic              e_valid;
  logic [WIDTH-1:0]  e_data;
  logic [STAGES-1:0] e_shamt;
  logic              e_fill;
  logic [WIDTH-1:0]  exit_data;

  logic              s_valid [0:STAGES];
  logic [WIDTH-1:0]  s_data  [0:STAGES];
  shift_mode_t       s_mode  [0:STAGES];
  logic [STAGES-1:0] s_shamt [0:STAGES];
  logic              s_fill  [0:STAGES];

  assign out_valid = rst_n && s_valid[STAGES];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = rst_n && !flush && advance;

  always_comb begin
    e_valid = in_valid && in_ready;
    e_fill  = (in_mode == MODE_SRA) && in_data[WIDTH-1];
    e_shamt = in_shamt;
    if ((in_mode == MODE_PASS) || (in_mode == MODE_PASS2)) e_shamt = '0;
    e_data = in_data;
    if (is_left(in_mode)) begin
      for (int i = 0; i < WIDTH; i++) e_data[i] = in_data[WIDTH-1-i];
    end
  end

  assign s_valid[0] = e_valid;
  assign s_data[0]  = e_data;
  assign s_mode[0]  = in_mode;
  assign s_shamt[0] = e_shamt;
  assign s_fill[0]  = e_fill;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    shifter_stage #(
      .WIDTH (WIDTH),
      .SHIFT (1 << (STAGES - 1 - k))
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .advance    (advance),
      .flush      (flush),
      .prev_valid (s_valid[k]),
      .prev_data  (s_data[k]),
      .prev_mode  (s_mode[k]),
      .prev_shamt (s_shamt[k]),
      .prev_fill  (s_fill[k]),
      .valid      (s_valid[k+1]),
      .data       (s_data[k+1]),
      .mode       (s_mode[k+1]),
      .shamt      (s_shamt[k+1]),
      .fill       (s_fill[k+1])
    );
  end

  // The last stage's shamt/fill have no consumer.
  logic unused_tail;
  assign unused_tail = ^{s_shamt[STAGES], s_fill[STAGES]};

  always_comb begin
    exit_data = s_data[STAGES];
    if (is_left(s_mode[STAGES])) begin
      for (int i = 0; i < WIDTH; i++) exit_data[i] = s_data[STAGES][WIDTH-1-i];
    end
    out_data = out_valid ? exit_data : '0;
  end

endmodule

// File: tb/tb_shifter_pipe.sv
// Scoreboard bench for shifter_pipe at WIDTH=32 and WIDTH=8, run side by side.
module tb_shifter_pipe;
  import shifter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit done [2];

  typedef struct {
    logic [127:0] d;
    int           acc;
    bit           lat;
  } exp_t;

  task automatic chk(input string nm, input int w, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (W=%0d): got %0h expected %0h", nm, w, act, exp);
    end
  endtask

  // Reference: plain arithmetic on a wide vector, masked to w bits.
  function automatic logic [127:0] ref_model(input logic [127:0] din, input int s,
                                             input int m, input int w);
    logic [127:0] mask;
    logic [127:0] d;
    logic [127:0] r;
    mask = (128'd1 << w) - 128'd1;
    d = din & mask;
    case (m)
      0:       r = d >> s;
      1: begin
        r = d >> s;
        if (d[w-1]) r = r | (mask & ~(mask >> s));
      end
      2, 3:    r = d << s;
      4:       r = (d >> s) | (d << (w - s));
      5:       r = (d << s) | (d >> (w - s));
      default: r = d;
    endcase
    return r & mask;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_w
    localparam int W = (g == 0) ? 32 : 8;
    localparam int S = log2(W);

    logic         rst_n, in_valid, in_ready, flush, out_valid, out_ready;
    logic [W-1:0] in_data, out_data;
    logic [S-1:0] in_shamt;
    shift_mode_t  in_mode;

    shifter_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_mode   (in_mode),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
    );

    exp_t         q[$];
    int           cyc = 0;
    bit           stalled = 1'b0;
    logic [W-1:0] stall_d;

    always @(posedge clk) cyc++;

    task automatic cyc_drive(input bit v, input logic [W-1:0] d, input logic [S-1:0] s,
                             input logic [2:0] m, input bit ordy, input bit fl,
                             input bit lat, output bit acc);
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      in_shamt  = s;
      in_mode   = shift_mode_t'(m);
      out_ready = ordy;
      flush     = fl;
      #1;
      acc = v && in_ready;
      if (fl) begin
        chk("flush_in_ready", W, in_ready, 0);
        q.delete();
      end
      if (acc) q.push_back('{d: ref_model(d, s, m, W), acc: cyc, lat: lat});
    endtask

    task automatic idle(input int n, input bit ordy);
      bit a;
      repeat (n) cyc_drive(0, '0, '0, 3'd0, ordy, 0, 0, a);
    endtask

    task automatic send(input logic [W-1:0] d, input logic [S-1:0] s, input logic [2:0] m);
      bit a;
      int c;
      a = 0;
      c = 0;
      while (!a && c < 50) begin
        cyc_drive(1, d, s, m, 1, 0, 1, a);
        c++;
      end
      if (!a) chk("send_timeout", W, 0, 1);
    endtask

    task automatic drain();
      int c;
      c = 0;
      while (q.size() != 0 && c < 200) begin
        idle(1, 1);
        c++;
      end
      idle(1, 1);
      chk("drain_empty", W, q.size(), 0);
    endtask

    // Monitor: pops on every output handshake, checks stall stability.
    always @(negedge clk) begin
      exp_t e;
      #2;
      if (!rst_n) begin
        chk("rst_out_valid", W, out_valid, 0);
        chk("rst_out_data", W, out_data, 0);
        chk("rst_in_ready", W, in_ready, 0);
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_valid", W, out_valid, 1);
          chk("stall_data", W, out_data, stall_d);
        end
        stalled = 1'b0;
        if (out_valid && !flush) begin
          if (q.size() == 0) begin
            chk("spurious_out", W, out_valid, 0);
          end else if (out_ready) begin
            e = q.pop_front();
            chk("data", W, out_data, e.d);
            if (e.lat) chk("latency", W, cyc - e.acc, S);
          end else begin
            stalled = 1'b1;
            stall_d = out_data;
          end
        end
      end
    end

    initial begin : stim
      bit a;
      int sent;
      int acc_n;
      bit v, ordy, fl;
      rst_n = 0; in_valid = 0; in_data = '0; in_shamt = '0;
      in_mode = MODE_SRL; flush = 0; out_ready = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      #1 chk("in_ready_after_rst", W, in_ready, 1);

      // Directed corner values
      send(W'(1) << (W - 1), S'(4), MODE_SRA);
      drain();
      send(W'(1), S'(W - 1), MODE_SLL);
      send(W'(32'hF1), S'(4), MODE_ROR);
      send((W'(1) << (W - 1)) | W'(1), S'(1), MODE_ROL);
      for (int m = 0; m < 8; m++) send(W'(32'hA5A5_5A5A), '0, 3'(m));
      drain();

      // Back-to-back stream with a 3-cycle consumer stall
      sent = 0;
      for (int c = 0; c < 40 && sent < 8; c++) begin
        ordy = !(c >= S + 1 && c <= S + 3);
        cyc_drive(1, W'(32'h1357_9BDF * (sent + 1)), S'(sent + 1), 3'(sent % 6),
                  ordy, 0, 0, a);
        if (a) sent++;
      end
      chk("stream_sent", W, sent, 8);
      drain();

      // Reset with three requests in flight
      for (int i = 0; i < 3; i++) cyc_drive(1, W'($urandom), S'($urandom), 3'(i), 1, 0, 0, a);
      @(negedge clk);
      rst_n = 0; in_valid = 0;
      q.delete();
      @(negedge clk);
      rst_n = 1;
      #1 chk("in_ready_after_midrst", W, in_ready, 1);
      idle(6, 1);
      send(W'(32'h8421_1248), S'(3), MODE_SRA);
      drain();

      // Flush with full pipeline and stalled consumer
      for (int c = 0; c < S + 3; c++) cyc_drive(1, W'($urandom), S'($urandom), 3'($urandom), 0, 0, 0, a);
      cyc_drive(1, W'($urandom), S'($urandom), 3'd0, 0, 1, 0, a);
      idle(1, 1);
      chk("flush_clears_valid", W, out_valid, 0);
      idle(8, 1);
      send(W'(32'hDEAD_BEEF), S'(2), MODE_ROL);
      drain();

      // Random traffic with random back-pressure and rare flushes
      acc_n = 0;
      for (int c = 0; c < 40000 && acc_n < 10000; c++) begin
        v    = ($urandom_range(0, 3) != 0);
        ordy = ($urandom_range(0, 3) != 0);
        fl   = ($urandom_range(0, 999) == 0);
        if (fl) ordy = 0;
        cyc_drive(v, W'($urandom), S'($urandom), 3'($urandom), ordy, fl, 0, a);
        if (a) acc_n++;
      end
      chk("random_count", W, acc_n, 10000);
      drain();
      done[g] = 1'b1;
    end
  end

  initial begin : summary
    int c;
    c = 0;
    while (!(done[0] && done[1]) && c < 95000) begin
      @(posedge clk);
      c++;
    end
    chk("timeout", 0, done[0] && done[1], 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
